// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP,
        RECOVER
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT_9600 = 5208;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to RST_VAL.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_pair.sv
// Receives two 8N1 bytes and presents them as one 16-bit word, byte 0 in the low half.
//   state   | meaning
//   IDLE    | line idle, waiting for a start edge
//   START   | confirming the start bit at its mid-point
//   DATA    | sampling 8 data bits, LSB first
//   STOP    | sampling the stop bit
//   GAP     | byte 0 held, waiting for byte 1's start bit
//   RECOVER | after a framing error, waiting for one full bit of idle line
module uart_rx_pair
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_9600,
    parameter int GAP_BITS     = 20
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] data,
    output logic        valid,
    output logic        frame_err,
    output logic        gap_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(GAP_BITS * CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LD_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LD_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(GAP_BITS * CLKS_PER_BIT - 1);

    uart_state_e      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic             byte_idx, byte_idx_d;
    logic [7:0]       shift, shift_d;
    logic [7:0]       byte0, byte0_d;
    logic [15:0]      data_q, data_d;
    logic             valid_d, ferr_d, gerr_d;
    logic             rx_s;
    logic             cnt_tc;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk_50mhz),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign cnt_tc = (cnt == '0);

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= 1'b0;
            shift     <= '0;
            byte0     <= '0;
            data_q    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            gap_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            byte_idx  <= byte_idx_d;
            shift     <= shift_d;
            byte0     <= byte0_d;
            data_q    <= data_d;
            valid     <= valid_d;
            frame_err <= ferr_d;
            gap_err   <= gerr_d;
        end
    end

    // Timers count down to zero and stall there; each state entry reloads them.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt_tc ? cnt : cnt - 1'b1;
        bit_idx_d  = bit_idx;
        byte_idx_d = byte_idx;
        shift_d    = shift;
        byte0_d    = byte0;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        gerr_d     = 1'b0;

        case (state)
            IDLE: begin
                byte_idx_d = 1'b0;
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = LD_HALF;
                end
            end
            START: begin
                if (cnt_tc) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = LD_BIT;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_tc) begin
                    shift_d[bit_idx] = rx_s;
                    cnt_d            = LD_BIT;
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_idx_d = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt_tc) begin
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                        cnt_d   = LD_BIT;
                    end else if (!byte_idx) begin
                        byte0_d = shift;
                        state_d = GAP;
                        cnt_d   = LD_GAP;
                    end else begin
                        data_d  = {shift, byte0};
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (!rx_s) begin
                    byte_idx_d = 1'b1;
                    state_d    = START;
                    cnt_d      = LD_HALF;
                end else if (cnt_tc) begin
                    gerr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                if (!rx_s)       cnt_d   = LD_BIT;
                else if (cnt_tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data = data_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_pair.sv
// Directed bench for uart_rx_pair with CLKS_PER_BIT=8, GAP_BITS=4.
module tb_uart_rx_pair;

    localparam int CPB  = 8;
    localparam int GAPB = 4;

    logic        clk_50mhz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        rx        = 1'b1;
    logic [15:0] data;
    logic        valid, frame_err, gap_err, busy;

    uart_rx_pair #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAPB)) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .gap_err   (gap_err),
        .busy      (busy)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    int cyc = 0;
    always @(posedge clk_50mhz) cyc <= cyc + 1;

    int          n_cmp = 0, n_mis = 0;
    int          n_valid = 0, n_ferr = 0, n_gerr = 0, n_overlap = 0;
    int          valid_cyc = -1, ferr_cyc = -1, gerr_cyc = -1, busy_fall_cyc = -1;
    logic        busy_prev = 1'b0;
    logic [15:0] got[$];

    always @(negedge clk_50mhz) begin
        if (valid) begin
            n_valid++;
            valid_cyc = cyc;
            got.push_back(data);
        end
        if (frame_err) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (gap_err) begin
            n_gerr++;
            gerr_cyc = cyc;
        end
        if (int'(valid) + int'(frame_err) + int'(gap_err) > 1) n_overlap++;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic sync_edge(output int e);
        @(posedge clk_50mhz);
        #1;
        e = cyc;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    int e, nv, nf, ng, base;

    initial begin
        // reset state
        repeat (3) @(posedge clk_50mhz);
        #1;
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_gerr", 32'(gap_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(5);

        // back-to-back pair
        nv = n_valid; nf = n_ferr; ng = n_gerr;
        sync_edge(e);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(5);
        chk("p1_nvalid", 32'(n_valid - nv), 32'd1);
        chk("p1_data", 32'(data), 32'h3CA5);
        chk("p1_valid_time", 32'(valid_cyc - e), 32'd159);
        chk("p1_errs", 32'((n_ferr - nf) + (n_gerr - ng)), 32'd0);
        chk("p1_busy", 32'(busy), 32'h0);

        // start-bit glitch
        nv = n_valid; nf = n_ferr; ng = n_gerr;
        sync_edge(e);
        rx = 1'b0;
        repeat (3) @(posedge clk_50mhz);
        #1;
        idle(12);
        chk("gl_busy_fall", 32'(busy_fall_cyc - e), 32'd7);
        chk("gl_busy", 32'(busy), 32'h0);
        chk("gl_pulses", 32'((n_valid - nv) + (n_ferr - nf) + (n_gerr - ng)), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h80, 1'b1);
        idle(5);
        chk("gl_pair_data", 32'(data), 32'h8001);
        chk("gl_pair_nvalid", 32'(n_valid - nv), 32'd1);

        // framing error on byte 0
        nv = n_valid; nf = n_ferr; ng = n_gerr;
        sync_edge(e);
        send_byte(8'h55, 1'b0);
        idle(20);
        chk("fe_count", 32'(n_ferr - nf), 32'd1);
        chk("fe_time", 32'(ferr_cyc - e), 32'd79);
        chk("fe_busy_fall", 32'(busy_fall_cyc - e), 32'd90);
        chk("fe_novalid", 32'(n_valid - nv), 32'd0);
        chk("fe_data_hold", 32'(data), 32'h8001);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(5);
        chk("fe_pair_data", 32'(data), 32'h3412);
        chk("fe_pair_nvalid", 32'(n_valid - nv), 32'd1);

        // inter-byte gap timeout
        nv = n_valid; nf = n_ferr; ng = n_gerr;
        sync_edge(e);
        send_byte(8'hFF, 1'b1);
        idle(40);
        chk("gap_count", 32'(n_gerr - ng), 32'd1);
        chk("gap_time", 32'(gerr_cyc - e), 32'd111);
        chk("gap_data_hold", 32'(data), 32'h3412);
        chk("gap_novalid", 32'(n_valid - nv), 32'd0);
        chk("gap_noferr", 32'(n_ferr - nf), 32'd0);
        chk("gap_busy", 32'(busy), 32'h0);

        // reset during byte 1, data bit 4
        nv = n_valid; nf = n_ferr; ng = n_gerr;
        send_byte(8'h0F, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        repeat (4) @(posedge clk_50mhz);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_50mhz);
        #1;
        chk("mr_data", 32'(data), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_valid", 32'(valid), 32'h0);
        rx = 1'b1;
        rst_n = 1'b1;
        idle(20);
        chk("mr_busy_after", 32'(busy), 32'h0);
        chk("mr_pulses", 32'((n_valid - nv) + (n_ferr - nf) + (n_gerr - ng)), 32'd0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle(5);
        chk("mr_pair_data", 32'(data), 32'hC35A);

        // three pairs with no idle time between them
        nv = n_valid;
        base = got.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        idle(5);
        chk("b2b_nvalid", 32'(n_valid - nv), 32'd3);
        if (got.size() >= base + 3) begin
            chk("b2b_data0", 32'(got[base]), 32'h0000);
            chk("b2b_data1", 32'(got[base + 1]), 32'hFFFF);
            chk("b2b_data2", 32'(got[base + 2]), 32'hBEEF);
        end else begin
            chk("b2b_captured", 32'(got.size() - base), 32'd3);
        end

        chk("pulse_overlap", 32'(n_overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
